count_scheduler: RTL and testbench

Shares a single prescaled interval counter between NUM_REQ requesters. Each requester asks for an interval of N counts, where one count is CYCLES_PER_COUNT enabled cycles. The block arbitrates round-robin, runs one interval at a time, and returns a one-cycle done pulse to the owner. It sits between requesting control blocks and the shared counting resource, and owns that resource's sequencing.

---
 rtl/count_scheduler.sv | 129 ++++++++++++
 tb/tb_count_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_scheduler.sv
// Round-robin scheduler sharing one prescaled interval counter between NUM_REQ requesters.
// One interval runs at a time; the owner receives a single-cycle done pulse on completion or cancel.
module count_scheduler #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned CYCLES_PER_COUNT = 8
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [8*NUM_REQ-1:0]   req_len_i,
  input  logic                   cancel_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic                   aborted_o,
  output logic                   busy_o,
  output logic [7:0]             count_o
);

  localparam int unsigned LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW = (CYCLES_PER_COUNT > 1) ? $clog2(CYCLES_PER_COUNT) : 1;
  localparam logic [PW-1:0] PS_MAX    = PW'(CYCLES_PER_COUNT - 1);
  localparam logic [LW-1:0] LAST_INIT = LW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0]      r_last, w_last_nxt;
  logic [7:0]         r_len, w_len_nxt;
  logic [7:0]         r_count, w_count_nxt;
  logic [PW-1:0]      r_prescale, w_prescale_nxt;
  logic               r_abort, w_abort_nxt;

  logic               w_found;
  logic [LW-1:0]      w_pick;
  logic [7:0]         w_pick_len;

  // Search upward from the requester after the last owner, wrapping at NUM_REQ.
  always_comb begin : arb
    int unsigned idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && req_i[idx]) begin
        w_found = 1'b1;
        w_pick  = LW'(idx);
      end
    end
  end

  assign w_pick_len = req_len_i[8*w_pick +: 8];

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last;
    w_len_nxt      = r_len;
    w_count_nxt    = r_count;
    w_prescale_nxt = r_prescale;
    w_abort_nxt    = r_abort;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_last_nxt          = w_pick;
          w_len_nxt           = w_pick_len;
          w_count_nxt         = '0;
          w_prescale_nxt      = '0;
          w_abort_nxt         = 1'b0;
          w_state_nxt         = (w_pick_len != 8'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Cancel wins over a coinciding final tick and freezes count.
        if (cancel_i) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end else if (enable_i) begin
          if (r_prescale == PS_MAX) begin
            w_prescale_nxt = '0;
            w_count_nxt    = r_count + 8'd1;
            if (r_count + 8'd1 == r_len) w_state_nxt = S_DONE;
          end else begin
            w_prescale_nxt = r_prescale + PW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_last     <= LAST_INIT;
      r_len      <= '0;
      r_count    <= '0;
      r_prescale <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_len      <= w_len_nxt;
      r_count    <= w_count_nxt;
      r_prescale <= w_prescale_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  assign grant_o   = r_grant;
  assign done_o    = (r_state == S_DONE) ? r_grant : '0;
  assign aborted_o = (r_state == S_DONE) && r_abort;
  assign busy_o    = (r_state != S_IDLE);
  assign count_o   = r_count;

endmodule

// File: tb/tb_count_scheduler.sv
// Directed bench for count_scheduler: a table-driven round-robin run plus hand sequences
// for pause, zero length, cancel and mid-interval reset, across three prescale settings.
module tb_count_scheduler;

  logic        clock = 1'b0;
  logic        reset_i, enable_i, cancel_i;
  logic [3:0]  req_i;
  logic [31:0] req_len_i;

  logic [3:0] g8, d8, g2, d2, g4, d4;
  logic       a8, b8, a2, b2, a4, b4;
  logic [7:0] c8, c2, c4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  count_scheduler #(.NUM_REQ(4), .CYCLES_PER_COUNT(8)) u_dut8 (
    .clock_i(clock), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
    .req_len_i(req_len_i), .cancel_i(cancel_i), .grant_o(g8), .done_o(d8),
    .aborted_o(a8), .busy_o(b8), .count_o(c8));

  count_scheduler #(.NUM_REQ(4), .CYCLES_PER_COUNT(2)) u_dut2 (
    .clock_i(clock), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
    .req_len_i(req_len_i), .cancel_i(cancel_i), .grant_o(g2), .done_o(d2),
    .aborted_o(a2), .busy_o(b2), .count_o(c2));

  count_scheduler #(.NUM_REQ(4), .CYCLES_PER_COUNT(4)) u_dut4 (
    .clock_i(clock), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
    .req_len_i(req_len_i), .cancel_i(cancel_i), .grant_o(g4), .done_o(d4),
    .aborted_o(a4), .busy_o(b4), .count_o(c4));

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic [3:0] grant;
    logic [3:0] done;
    logic [7:0] count;
    logic       busy;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_i   = 1'b1;
    enable_i  = 1'b1;
    cancel_i  = 1'b0;
    req_i     = '0;
    req_len_i = '0;
    step();
    step();
    chk("rst_grant", g8, 0);
    chk("rst_done", d8, 0);
    chk("rst_abort", a8, 0);
    chk("rst_busy", b8, 0);
    chk("rst_count", c8, 0);
    reset_i = 1'b0;
  endtask

  initial begin
    // Round robin, C=2, all lengths 1: expected values for the cycle after each input row.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0000, 8'd0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 4'b0000, 8'd0, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 8'd1, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 8'd1, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 4'b0000, 8'd0, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0000, 8'd0, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 8'd1, 1'b1};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 8'd1, 1'b0};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0100, 4'b0000, 8'd0, 1'b1};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 4'b0000, 8'd0, 1'b1};
    tbl[10] = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 8'd1, 1'b1};
    tbl[11] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 8'd1, 1'b0};
    tbl[12] = '{4'b1111, 1'b1, 4'b1000, 4'b0000, 8'd0, 1'b1};
    tbl[13] = '{4'b1111, 1'b1, 4'b1000, 4'b0000, 8'd0, 1'b1};
    tbl[14] = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 8'd1, 1'b1};
    tbl[15] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 8'd1, 1'b0};
    tbl[16] = '{4'b1111, 1'b1, 4'b0001, 4'b0000, 8'd0, 1'b1};

    // Basic interval: C=8, len0=3.
    do_reset();
    req_i     = 4'b0001;
    req_len_i = {8'd0, 8'd0, 8'd0, 8'd3};
    for (int k = 1; k <= 26; k++) begin
      step();
      req_i = '0;
      if (k <= 25) begin
        chk("t1_grant", g8, 1);
        chk("t1_busy", b8, 1);
        chk("t1_count", c8, (k - 1) / 8);
        chk("t1_done", d8, (k == 25) ? 1 : 0);
        chk("t1_abort", a8, 0);
      end else begin
        chk("t1_idle_grant", g8, 0);
        chk("t1_idle_busy", b8, 0);
        chk("t1_hold_count", c8, 3);
        chk("t1_idle_done", d8, 0);
      end
    end

    // Table-driven round robin on the C=2 instance.
    do_reset();
    req_len_i = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 17; i++) begin
      req_i    = tbl[i].req;
      enable_i = tbl[i].en;
      step();
      chk("rr_grant", g2, tbl[i].grant);
      chk("rr_done", d2, tbl[i].done);
      chk("rr_count", c2, tbl[i].count);
      chk("rr_busy", b2, tbl[i].busy);
    end

    // Cancel coinciding with the final tick (C=2, len=1): count must not advance.
    do_reset();
    req_i     = 4'b0001;
    req_len_i = {8'd1, 8'd1, 8'd1, 8'd1};
    step();
    req_i = '0;
    step();
    cancel_i = 1'b1;
    step();
    cancel_i = 1'b0;
    chk("ctick_done", d2, 1);
    chk("ctick_abort", a2, 1);
    chk("ctick_count", c2, 0);
    step();
    chk("ctick_idle_abort", a2, 0);
    chk("ctick_idle_busy", b2, 0);

    // Zero length on requester 2.
    do_reset();
    req_i     = 4'b0100;
    req_len_i = '0;
    step();
    req_i = '0;
    chk("z_grant", g8, 4);
    chk("z_done", d8, 4);
    chk("z_count", c8, 0);
    chk("z_abort", a8, 0);
    step();
    chk("z_idle_grant", g8, 0);
    chk("z_idle_done", d8, 0);
    chk("z_idle_busy", b8, 0);

    // Pause: C=4, len=2, enable low for cycles 5..9 -> done at 14 instead of 9.
    do_reset();
    req_i     = 4'b0001;
    req_len_i = {8'd0, 8'd0, 8'd0, 8'd2};
    for (int k = 1; k <= 15; k++) begin
      step();
      req_i = '0;
      if (k <= 14) begin
        chk("p_count", c4, (k < 5) ? 0 : ((k < 14) ? 1 : 2));
        chk("p_done", d4, (k == 14) ? 1 : 0);
        chk("p_grant", g4, 1);
      end else begin
        chk("p_idle_busy", b4, 0);
      end
      enable_i = !(k >= 5 && k <= 9);
    end
    enable_i = 1'b1;

    // Cancel after count=2 (C=8, len=5), then cancel in IDLE has no effect.
    do_reset();
    req_i     = 4'b0001;
    req_len_i = {8'd0, 8'd0, 8'd0, 8'd5};
    for (int k = 1; k <= 17; k++) begin
      step();
      req_i = '0;
    end
    chk("c_count_before", c8, 2);
    cancel_i = 1'b1;
    step();
    cancel_i = 1'b0;
    chk("c_done", d8, 1);
    chk("c_abort", a8, 1);
    chk("c_count", c8, 2);
    chk("c_grant", g8, 1);
    step();
    chk("c_idle_done", d8, 0);
    chk("c_idle_abort", a8, 0);
    chk("c_idle_count", c8, 2);
    chk("c_idle_busy", b8, 0);
    req_i     = 4'b0010;
    req_len_i = {8'd0, 8'd0, 8'd1, 8'd5};
    cancel_i  = 1'b1;
    step();
    cancel_i = 1'b0;
    req_i    = '0;
    chk("ci_grant", g8, 2);
    chk("ci_busy", b8, 1);
    chk("ci_done", d8, 0);
    chk("ci_count", c8, 0);

    // Reset during RUN at count=3, then requester 0 wins over 3.
    do_reset();
    req_i     = 4'b0001;
    req_len_i = {8'd0, 8'd0, 8'd0, 8'd5};
    for (int k = 1; k <= 25; k++) begin
      step();
      req_i = '0;
    end
    chk("r_count_before", c8, 3);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("r_grant", g8, 0);
    chk("r_done", d8, 0);
    chk("r_abort", a8, 0);
    chk("r_busy", b8, 0);
    chk("r_count", c8, 0);
    req_i = 4'b1001;
    step();
    req_i = '0;
    chk("r_regrant", g8, 1);
    chk("r_regrant_done", d8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
